// File: rtl/cu_sequencer.sv
// Multi-cycle control-unit sequencer: fetch, execute micro-steps, RAM stalls and step-fault detection.
// Optional HALT phase is built when CU_HALT_EN is defined.

package cu_sequencer_pkg;

    typedef struct packed {
        logic       alu_en;
        logic       alu_bs;
        logic [4:0] alu_fs;
        logic       rf_b_en;
        logic [4:0] rf_sa;
        logic [4:0] rf_sb;
        logic [4:0] rf_da;
        logic       rf_w;
        logic       ram_en;
        logic       ram_w;
        logic       pc_en;
        logic [1:0] pc_fs;
        logic       pc_is;
        logic       status_ld;
        logic [1:0] next_state;
    } cw_t;

    // Register addresses parked at 31, everything else idle, PC held.
    localparam cw_t CW_SAFE = cw_t'(33'h1FFFC00);

endpackage

module cu_sequencer
    import cu_sequencer_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] imem_data,
    input  logic        imem_ack,
    output logic        imem_req,
    input  logic [32:0] cw_in,
    input  logic [4:0]  alu_status,
    input  logic        ram_ready,
    output logic [31:0] I,
    output logic [1:0]  state,
    output logic [4:0]  status,
    output logic [32:0] cw_out,
    output logic        fault,
    output logic        halted
);

    localparam int unsigned IW    = 32;
    localparam int unsigned SW    = 2;
    localparam int unsigned STW   = 5;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PH_W  = 2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MAX_STEPS - 1);

    localparam logic [PH_W-1:0] PH_FETCH = 2'd0;
    localparam logic [PH_W-1:0] PH_EXEC  = 2'd1;
`ifdef CU_HALT_EN
    localparam logic [PH_W-1:0] PH_HALT  = 2'd2;
    localparam logic [IW-1:0]   HALT_WORD = 32'hD440_0000;
`endif

    logic [PH_W-1:0]  phase_q,  phase_d;
    logic [IW-1:0]    ir_q,     ir_d;
    logic [SW-1:0]    state_q,  state_d;
    logic [STW-1:0]   status_q, status_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             fault_q,  fault_d;

    cw_t  cw;
    cw_t  cw_o;
    logic stall;

    assign cw    = cw_t'(cw_in);
    assign stall = (cw.ram_en | cw.ram_w) & ~ram_ready;

    // Phase and architectural registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_FETCH;
            ir_q     <= '0;
            state_q  <= '0;
            status_q <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            ir_q     <= ir_d;
            state_q  <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and control-word gating
    always_comb begin
        phase_d  = phase_q;
        ir_d     = ir_q;
        state_d  = state_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        imem_req = 1'b0;
        cw_o     = CW_SAFE;

        case (phase_q)
            PH_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = '0;
                    cnt_d   = '0;
`ifdef CU_HALT_EN
                    phase_d = (imem_data == HALT_WORD) ? PH_HALT : PH_EXEC;
`else
                    phase_d = PH_EXEC;
`endif
                end
            end

            PH_EXEC: begin
                if (stall) begin
                    // Keep the RAM access and addressing alive, suppress every commit.
                    cw_o            = cw;
                    cw_o.rf_w       = 1'b0;
                    cw_o.pc_fs      = 2'b00;
                    cw_o.status_ld  = 1'b0;
                    cw_o.next_state = 2'b00;
                end else if ((cw.next_state != 2'b00) && (cnt_q == LAST_STEP)) begin
                    fault_d = 1'b1;
                    cw_o    = CW_SAFE;
                    phase_d = PH_FETCH;
                    state_d = '0;
                end else begin
                    cw_o = cw;
                    if (cw.status_ld) begin
                        status_d = alu_status;
                    end
                    if (cw.next_state == 2'b00) begin
                        phase_d = PH_FETCH;
                        state_d = '0;
                    end else begin
                        state_d = cw.next_state;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end

`ifdef CU_HALT_EN
            PH_HALT: begin
                imem_req = 1'b0;
                cw_o     = CW_SAFE;
            end
`endif

            default: begin
                phase_d = PH_FETCH;
            end
        endcase
    end

    assign cw_out = cw_o;
    assign I      = ir_q;
    assign state  = state_q;
    assign status = status_q;
    assign fault  = fault_q;

`ifdef CU_HALT_EN
    assign halted = (phase_q == PH_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed self-checking bench for cu_sequencer (MAX_STEPS = 4).

module tb_cu_sequencer;

    localparam logic [32:0] SAFE = 33'h1FFFC00;

    logic        clock;
    logic        reset;
    logic [31:0] imem_data;
    logic        imem_ack;
    logic        imem_req;
    logic [32:0] cw_in;
    logic [4:0]  alu_status;
    logic        ram_ready;
    logic [31:0] I;
    logic [1:0]  state;
    logic [4:0]  status;
    logic [32:0] cw_out;
    logic        fault;
    logic        halted;

    int tests;
    int errors;

    cu_sequencer #(.MAX_STEPS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_data  (imem_data),
        .imem_ack   (imem_ack),
        .imem_req   (imem_req),
        .cw_in      (cw_in),
        .alu_status (alu_status),
        .ram_ready  (ram_ready),
        .I          (I),
        .state      (state),
        .status     (status),
        .cw_out     (cw_out),
        .fault      (fault),
        .halted     (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Non-trivial ALU/address fields so gating errors are visible.
    function automatic logic [32:0] mk_cw(input logic [1:0] ns, input logic ram_en,
                                          input logic status_ld, input logic rf_w,
                                          input logic [1:0] pc_fs);
        return {1'b1, 1'b0, 5'd3, 1'b1, 5'd2, 5'd3, 5'd4, rf_w, ram_en, 1'b0, 1'b1,
                pc_fs, 1'b0, status_ld, ns};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic fetch(input logic [31:0] word);
        imem_data = word;
        imem_ack  = 1'b1;
        tick();
        imem_ack  = 1'b0;
    endtask

    initial begin
        tests      = 0;
        errors     = 0;
        reset      = 1'b1;
        imem_data  = '0;
        imem_ack   = 1'b0;
        cw_in      = '0;
        alu_status = '0;
        ram_ready  = 1'b1;

        // Reset state
        settle();
        check("rst_req",    64'(imem_req), 64'd1);
        check("rst_cw",     64'(cw_out),   64'(SAFE));
        check("rst_fault",  64'(fault),    64'd0);
        check("rst_halted", 64'(halted),   64'd0);
        check("rst_I",      64'(I),        64'd0);
        check("rst_status", 64'(status),   64'd0);
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("post_rst_req", 64'(imem_req), 64'd1);
        check("post_rst_cw",  64'(cw_out),   64'(SAFE));

        // Single-step instruction
        cw_in = mk_cw(2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
        fetch(32'hD280_0541);
        check("t1_I",     64'(I),        64'hD2800541);
        check("t1_state", 64'(state),    64'd0);
        check("t1_req",   64'(imem_req), 64'd0);
        check("t1_cw",    64'(cw_out),   64'(mk_cw(2'd0, 1'b0, 1'b0, 1'b1, 2'd1)));
        tick();
        check("t1_fetch_req", 64'(imem_req), 64'd1);
        check("t1_fetch_cw",  64'(cw_out),   64'(SAFE));

        // Three-step sequence; acks during EXEC are ignored
        fetch(32'h1111_2222);
        imem_data = 32'hFFFF_FFFF;
        imem_ack  = 1'b1;
        cw_in = mk_cw(2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        settle();
        check("t2_state0", 64'(state), 64'd0);
        tick();
        cw_in = mk_cw(2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        settle();
        check("t2_state1", 64'(state), 64'd1);
        tick();
        cw_in = mk_cw(2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        settle();
        check("t2_state2", 64'(state), 64'd2);
        check("t2_I_kept", 64'(I),     64'h11112222);
        imem_ack = 1'b0;
        tick();
        check("t2_fetch_req", 64'(imem_req), 64'd1);
        check("t2_fault",     64'(fault),    64'd0);

        // RAM stall for three cycles, then completion with status load
        fetch(32'h3333_4444);
        cw_in      = mk_cw(2'd1, 1'b1, 1'b1, 1'b1, 2'd2);
        alu_status = 5'b10101;
        ram_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_stall_cw",    64'(cw_out), 64'(mk_cw(2'd0, 1'b1, 1'b0, 1'b0, 2'd0)));
            check("t3_stall_state", 64'(state),  64'd0);
            tick();
        end
        check("t3_stall_status", 64'(status), 64'd0);
        ram_ready = 1'b1;
        settle();
        check("t3_go_cw", 64'(cw_out), 64'(mk_cw(2'd1, 1'b1, 1'b1, 1'b1, 2'd2)));
        tick();
        check("t3_state",  64'(state),  64'd1);
        check("t3_status", 64'(status), 64'b10101);
        // Status load offered during a stall must not take effect
        cw_in      = mk_cw(2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
        alu_status = 5'b01010;
        ram_ready  = 1'b0;
        tick();
        check("t3_stall_hold_status", 64'(status), 64'b10101);
        check("t3_stall_hold_state",  64'(state),  64'd1);
        cw_in     = mk_cw(2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        ram_ready = 1'b1;
        tick();
        check("t3_end_req",    64'(imem_req), 64'd1);
        check("t3_end_status", 64'(status),   64'b10101);

        // Step overflow after MAX_STEPS execute cycles
        fetch(32'h5555_6666);
        cw_in = mk_cw(2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t4_cw",    64'(cw_out), 64'(mk_cw(2'd1, 1'b0, 1'b0, 1'b0, 2'd0)));
            check("t4_fault", 64'(fault),  64'd0);
            tick();
        end
        settle();
        check("t4_ovf_cw", 64'(cw_out), 64'(SAFE));
        tick();
        check("t4_fault_set", 64'(fault),    64'd1);
        check("t4_fetch_req", 64'(imem_req), 64'd1);
        check("t4_state",     64'(state),    64'd0);

        // Fault stays set across a clean instruction
        cw_in = mk_cw(2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        fetch(32'h7777_8888);
        tick();
        check("t5_sticky", 64'(fault), 64'd1);

        // Reset mid-EXEC aborts without committing
        cw_in      = mk_cw(2'd1, 1'b0, 1'b1, 1'b0, 2'd0);
        alu_status = 5'b11111;
        fetch(32'h9999_AAAA);
        check("t6_in_exec", 64'(imem_req), 64'd0);
        reset = 1'b1;
        settle();
        check("t6_rst_req",    64'(imem_req), 64'd1);
        check("t6_rst_cw",     64'(cw_out),   64'(SAFE));
        check("t6_rst_fault",  64'(fault),    64'd0);
        check("t6_rst_status", 64'(status),   64'd0);
        check("t6_rst_I",      64'(I),        64'd0);
        tick();
        reset = 1'b0;
        settle();

        // Halt word
        cw_in = mk_cw(2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
        fetch(32'hD440_0000);
        check("t7_I", 64'(I), 64'hD4400000);
`ifdef CU_HALT_EN
        check("t7_halted", 64'(halted),   64'd1);
        check("t7_req",    64'(imem_req), 64'd0);
        check("t7_cw",     64'(cw_out),   64'(SAFE));
        tick();
        tick();
        check("t7_halt_hold", 64'(halted), 64'd1);
        reset = 1'b1;
        settle();
        check("t7_rst_halted", 64'(halted),   64'd0);
        check("t7_rst_req",    64'(imem_req), 64'd1);
        tick();
        reset = 1'b0;
`else
        check("t7_halted", 64'(halted),   64'd0);
        check("t7_req",    64'(imem_req), 64'd0);
        check("t7_cw",     64'(cw_out),   64'(mk_cw(2'd0, 1'b0, 1'b0, 1'b1, 2'd1)));
        tick();
        check("t7_fetch_req", 64'(imem_req), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Multi-cycle control-unit sequencer for the single-bus datapath. It owns three registers: the instruction register, the 2-bit micro-step (`state`) and the 5-bit status register. It presents these to the instruction-word decoder bank, takes back the selected 33-bit control word, gates it into the control word actually driven to the datapath, and sequences fetch, execute steps and RAM stalls.

## Interface
- `MAX_STEPS`, default 4: execute cycles allowed per instruction before a step fault is declared (range 1..15).
- `clock`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `imem_data`  in  32: instruction word from instruction memory.
- `imem_ack`  in  1: `imem_data` is valid this cycle.
- `imem_req`  out  1: fetch request.
- `cw_in`  in  33: control word from the decoder bank for the current `I`/`state`/`status`.
- `alu_status`  in  5: ALU flags.
- `ram_ready`  in  1: RAM completes the access this cycle.
- `I`  out  32: instruction register, to decoders.
- `state`  out  2: micro-step, to decoders.
- `status`  out  5: status register, to decoders.
- `cw_out`  out  33: control word driven to the datapath.
- `fault`  out  1: sticky step-overflow flag.
- `halted`  out  1: halt reached; only present with `CU_HALT_EN`.

## Operation
- Control-word field positions, MSB to LSB:
  - alu_en[32], alu_bs[31], alu_fs[30:26], rf_b_en[25]
  - rf_sa[24:20], rf_sb[19:15], rf_da[14:10], rf_w[9]
  - ram_en[8], ram_w[7], pc_en[6], pc_fs[5:4], pc_is[3]
  - status_ld[2], next_state[1:0]
- Safe word (SAFE): all bits 0, except rf_sa = rf_sb = rf_da = 31. This gives pc_fs = 00 (PC hold).
- Phase FSM: FETCH, EXEC, HALT (HALT only with the macro).
- FETCH:
  - `imem_req` = 1; `cw_out` = SAFE.
  - On `imem_ack`: I ← `imem_data`, `state` ← 0, step count ← 0, go to EXEC.
- EXEC:
  - `imem_req` = 0; `cw_out` is derived from `cw_in`.
  - Stall condition: (`cw_in`.ram_en | `cw_in`.ram_w) & !`ram_ready`.
  - During a stall:
    - `cw_out` = `cw_in` with rf_w, pc_fs, status_ld and next_state forced to 0.
    - ram_en, ram_w and the address/ALU fields stay driven.
    - All registers hold.
  - Not stalled:
    - `cw_out` = `cw_in`.
    - If status_ld = 1: status ← `alu_status`.
    - If next_state = 0: go to FETCH and `state` ← 0.
    - Otherwise: `state` ← next_state, step count +1, stay in EXEC.
- Step overflow: a non-stalled EXEC cycle with next_state ≠ 0 while step count = MAX_STEPS-1 causes:
  - `fault` ← 1 (sticky until reset);
  - `cw_out` = SAFE for that cycle;
  - go to FETCH.
- Stall cycles do not advance the step count.

## Timing
- `cw_out`, `imem_req` and `fault` are Moore/combinational from registers and `cw_in`/`ram_ready`. There is no registered output latency.
- IR, `state` and `status` update on the rising edge following the qualifying cycle.
- A single-step instruction is 1 fetch cycle (with immediate ack) + 1 EXEC cycle = 2 cycles.
- Reset values: phase = FETCH, I = 0, `state` = 0, `status` = 0, `fault` = 0, `halted` = 0, step count = 0.
  - Consequently `imem_req` = 1 and `cw_out` = SAFE during and immediately after reset.
- Reset asserted mid-EXEC or mid-stall aborts the instruction immediately. No partial register write is committed after the reset edge.
- `imem_ack` outside FETCH is ignored.
- A `ram_ready` held low indefinitely stalls indefinitely. This is not a fault.
- `alu_status` is sampled only on a non-stalled cycle with status_ld = 1.

## Configuration
- `CU_HALT_EN` defined:
  - In FETCH, an acked word equal to 32'hD440_0000 goes to HALT instead of EXEC. I still loads.
  - HALT: `cw_out` = SAFE, `imem_req` = 0, `halted` = 1. It is exited only by reset.
- `CU_HALT_EN` undefined:
  - No HALT state; `halted` is tied to 0.
  - 32'hD440_0000 executes through the decoder like any other word.

## Test plan
- Reset, then `imem_ack` with 32'hD2800541 and `cw_in`.next_state = 0 → EXEC for 1 cycle, then `cw_out` = `cw_in`; next cycle is FETCH with `imem_req` = 1 and `cw_out` = SAFE.
- `cw_in`.next_state sequence 1, 2, 0 → `state` outputs 0, 1, 2 on consecutive cycles, then FETCH; `fault` = 0.
- ram_en = 1 with `ram_ready` low for 3 cycles → `cw_out`.rf_w, pc_fs and status_ld are 0 for those cycles and `state` holds; on the 4th cycle `cw_out` = `cw_in`.
- status_ld = 1 with `alu_status` = 5'b10101 on a non-stalled cycle → `status` = 5'b10101 next cycle; the same input during a stall leaves `status` unchanged.
- `cw_in`.next_state held at 1 with MAX_STEPS = 4 → `fault` rises on the 4th EXEC cycle, that cycle's `cw_out` = SAFE, then FETCH.
- `CU_HALT_EN`: fetch 32'hD440_0000 → `halted` = 1 and `imem_req` = 0 until reset; asserting reset mid-HALT gives FETCH with `halted` = 0.
